// File: rtl/uart_tx_pkg.sv
// Shared constants and state encoding for the fifo-draining UART transmitter.
package uart_tx_pkg;

  localparam int unsigned DATA_BITS = 8;

  // Parity sense: 0 gives even parity (bit makes total ones even), 1 gives odd.
  localparam logic PARITY_ODD = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, reloads on each bit boundary,
// held at zero while clear is high. bit_tick marks the last cycle of a bit.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = !clear && (cnt == LAST);

  // Counter register: cleared outside a frame, reloaded at each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from an 8-bit synchronous fifo and shifts each out as an
// async-serial frame: start, 8 data bits LSB first, optional parity, stop bit(s).
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] buf_out,
  input  logic       buf_empty,
  output logic       rd_en,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t     state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       par_bit, par_bit_n;
  logic       tx_n;
  logic       baud_clr;
  logic       bit_tick;
  logic       frame_go;

  assign frame_go  = tx_en && !buf_empty;
  assign baud_clr  = (state == IDLE) || (state == FETCH) || (state == LOAD);
  assign byte_done = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (baud_clr),
    .bit_tick(bit_tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath decode; tx/rd_en/busy are derived from the next
  // state so that they can be registered and still line up with the state.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    par_bit_n = par_bit;
    case (state)
      IDLE: begin
        if (frame_go) state_n = FETCH;
      end
      FETCH: begin
        state_n = LOAD;
      end
      LOAD: begin
        shift_n   = buf_out;
        par_bit_n = (^buf_out) ^ PARITY_ODD;
        bit_cnt_n = '0;
        state_n   = START;
      end
      START: begin
        if (bit_tick) state_n = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
            state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_n = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_n = '0;
            state_n   = frame_go ? FETCH : IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_bit_n;
      default: tx_n = 1'b1;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      rd_en   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      par_bit <= par_bit_n;
      tx      <= tx_n;
      rd_en   <= (state_n == FETCH);
      busy    <= (state_n != IDLE);
    end
  end

endmodule
